sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares one single-ported synchronous SRAM between the instruction-fetch requester (IF stage) and the data requester (EX/MA stages) of the five-stage pipeline. Grant is decided combinationally in the request cycle. Read data returns one cycle later and is routed to the owning requester. Data accesses win by default; a bounded starvation guard keeps fetch making forward progress.

## Interface
- STARVE_MAX, 3: consecutive lost inst conflicts before inst is forced to win; legal range 1..15.
- ADDR_W, 32: address width.
- clk  in  1  rising-edge clock.
- resetn  in  1  reset, asynchronous, active-low.
- i_req  in  1  inst request; held, with i_we/i_addr/i_wdata stable, until i_gnt.
- i_we  in  4  inst byte write enables; 0 = read.
- i_addr  in  ADDR_W  inst address.
- i_wdata  in  32  inst write data.
- i_gnt  out  1  inst access issued this cycle.
- i_rvalid  out  1  inst read data valid.
- i_rdata  out  32  inst read data; 0 when i_rvalid is low.
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: same meanings and widths for the data requester.
- sram_en  out  1  SRAM enable.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid the cycle after a read enable.
- conflict_cnt  out  32  saturating count of cycles with i_req and d_req both high.

## Operation
- Grant, combinational:
  - Only one request high: that request is granted.
  - Both high: data is granted unless starve_cnt == STARVE_MAX, in which case inst is granted.
  - Neither high: no grant.
- SRAM drive:
  - sram_en = i_gnt | d_gnt.
  - sram_we/addr/wdata are muxed from the granted port.
  - All four SRAM outputs are 0 when there is no grant.
- starve_cnt, width 4:
  - Increments when both requests are high and data is granted.
  - Clears to 0 when inst is granted or i_req is low.
  - Never exceeds STARVE_MAX.
- Response tracking: register rsp_own ∈ {NONE, INST, DATA}.
  - Next state is INST or DATA if the granted access has we == 0; otherwise NONE.
  - Writes complete at grant and produce no rvalid.
- Response outputs:
  - x_rvalid = (rsp_own == X).
  - x_rdata = sram_rdata when x_rvalid is high, else 0.
- conflict_cnt increments on each cycle with both requests high and holds at 0xFFFF_FFFF.

## Timing
- Grant latency: 0 cycles (same cycle as request).
- Read latency: 1 cycle, grant edge to rvalid.
- Back-to-back grants are legal every cycle. A new grant may be issued in the same cycle as the previous read's rvalid.
- Reset values: rsp_own = NONE, starve_cnt = 0, conflict_cnt = 0, both rvalid = 0.
- Reset applied mid-read discards the in-flight read; no rvalid follows the reset release.
- Request dropped before grant: nothing is issued. starve_cnt clears only if it was i_req that dropped.
- Same-address write by data and read by inst in the same cycle: data wins (counter permitting). The inst read is issued later and observes the new value.

## Configuration
- ARB_STARVE_EN defined: starvation guard as described above.
- ARB_STARVE_EN undefined:
  - starve_cnt is removed.
  - Strict data priority whenever both requests are high.
  - STARVE_MAX is ignored.
- conflict_cnt is present in both builds.

## Test plan
- Reset with i_req = 1, i_addr = 0x1C000000:
  - All outputs 0 during reset.
  - First cycle after release: i_gnt = 1, sram_addr = 0x1C000000.
  - Next cycle: i_rvalid = 1, i_rdata equals the SRAM word.
- Data write then data read, d_we = 0xF, d_addr = 0x100, d_wdata = 0xDEADBEEF:
  - Write: d_gnt = 1, no d_rvalid.
  - Next-cycle read of 0x100: d_rvalid = 1, d_rdata = 0xDEADBEEF one cycle later.
- Both requesting continuously with ARB_STARVE_EN and STARVE_MAX = 3:
  - Grant pattern D, D, D, I repeating.
  - conflict_cnt = 8 after 8 cycles.
- Same stimulus with ARB_STARVE_EN undefined:
  - d_gnt every cycle, i_gnt never.
  - conflict_cnt increments every cycle.
- Read issued, resetn pulsed low the following cycle: no i_rvalid or d_rvalid after release; conflict_cnt = 0.
- conflict_cnt preloaded (force) to 0xFFFFFFFE, then 3 conflict cycles: conflict_cnt reads 0xFFFFFFFF and holds.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares one single-ported synchronous SRAM between the instruction-fetch
// requester (inst) and the data requester (data). The grant is decided
// combinationally in the request cycle. Data wins when both ports request.
// Read data comes back one cycle after the grant and is routed to whichever
// port issued the read. Writes complete at grant and produce no rvalid.
//
// Build option:
//   ARB_STARVE_EN  - when defined, a starvation guard lets inst win after
//                    STARVE_MAX consecutive lost conflicts. When undefined,
//                    data has strict priority and STARVE_MAX has no effect.
//
// Parameters:
//   STARVE_MAX  consecutive lost inst conflicts before inst is forced (1..15)
//   ADDR_W      address width
//
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   i_req/i_we/i_addr/i_wdata         inst request (held until i_gnt)
//   i_gnt, i_rvalid, i_rdata          inst grant and read response
//   d_req/d_we/d_addr/d_wdata         data request (held until d_gnt)
//   d_gnt, d_rvalid, d_rdata          data grant and read response
//   sram_en/we/addr/wdata, sram_rdata SRAM port (rdata valid the cycle after
//                                     a read enable)
//   conflict_cnt                      saturating count of cycles with both
//                                     requests high
module sram_port_arbiter #(
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [3:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic [31:0]       conflict_cnt
);

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_INST = 2'd1,
    RSP_DATA = 2'd2
  } rsp_own_e;

  rsp_own_e    r_rsp_own;
  rsp_own_e    w_rsp_own_next;
  logic [31:0] r_conflict_cnt;
  logic        w_conflict;
  logic        w_inst_wins;
  logic        w_i_gnt;
  logic        w_d_gnt;
  logic        w_i_rvalid;
  logic        w_d_rvalid;

  assign w_conflict = i_req & d_req;

`ifdef ARB_STARVE_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;

  assign w_inst_wins = (r_starve_cnt == STARVE_LIM);

  // Counts conflicts that inst lost in a row. Granting inst, or inst not
  // asking at all, breaks the run. Because inst wins at STARVE_LIM, the
  // counter never goes past it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve_cnt <= 4'd0;
    end else if (!i_req || w_i_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (w_conflict) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`else
  // STARVE_MAX has no effect without the starvation guard.
  localparam int unsigned starve_max_unused = STARVE_MAX;

  assign w_inst_wins = 1'b0;
`endif

  // Grants are masked while reset is held so the SRAM stays idle even if a
  // requester is already asserting its request.
  assign w_i_gnt = resetn & i_req & (~d_req | w_inst_wins);
  assign w_d_gnt = resetn & d_req & (~i_req | ~w_inst_wins);

  assign i_gnt = w_i_gnt;
  assign d_gnt = w_d_gnt;

  // SRAM drive and next response owner. Only reads expect data back.
  always_comb begin
    w_rsp_own_next = RSP_NONE;
    sram_en        = 1'b0;
    sram_we        = 4'd0;
    sram_addr      = '0;
    sram_wdata     = 32'd0;
    if (w_d_gnt) begin
      sram_en    = 1'b1;
      sram_we    = d_we;
      sram_addr  = d_addr;
      sram_wdata = d_wdata;
      if (d_we == 4'd0) begin
        w_rsp_own_next = RSP_DATA;
      end
    end else if (w_i_gnt) begin
      sram_en    = 1'b1;
      sram_we    = i_we;
      sram_addr  = i_addr;
      sram_wdata = i_wdata;
      if (i_we == 4'd0) begin
        w_rsp_own_next = RSP_INST;
      end
    end
  end

  // Reset clears the owner, so a read in flight at reset never returns.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rsp_own <= RSP_NONE;
    end else begin
      r_rsp_own <= w_rsp_own_next;
    end
  end

  assign w_i_rvalid = (r_rsp_own == RSP_INST);
  assign w_d_rvalid = (r_rsp_own == RSP_DATA);

  assign i_rvalid = w_i_rvalid;
  assign d_rvalid = w_d_rvalid;
  assign i_rdata  = w_i_rvalid ? sram_rdata : 32'd0;
  assign d_rdata  = w_d_rvalid ? sram_rdata : 32'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_conflict_cnt <= 32'd0;
    end else if (w_conflict && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter. Expected grants and read
// responses are queued when stimulus is issued; a monitor on the falling
// edge pops and compares them against what the DUT presents.
`timescale 1ns/1ps
module tb_sram_port_arbiter;

  localparam int OWN_I = 1;
  localparam int OWN_D = 2;

  logic        clk;
  logic        resetn;
  logic        i_req, d_req;
  logic [3:0]  i_we, d_we;
  logic [31:0] i_addr, d_addr, i_wdata, d_wdata;
  logic        i_gnt, d_gnt, i_rvalid, d_rvalid;
  logic [31:0] i_rdata, d_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic [31:0] conflict_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          owner;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          due;
  } gnt_t;

  typedef struct {
    int          owner;
    logic [31:0] data;
    int          due;
  } rd_t;

  gnt_t gnt_q[$];
  rd_t  rd_q[$];

  sram_port_arbiter #(.STARVE_MAX(3), .ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: unwritten words read back as ~address.
  logic [31:0] mem [256];
  logic        mem_vld [256];
  logic        mem_clr;
  logic [7:0]  mem_idx;
  assign mem_idx = sram_addr[9:2];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 256; k++) mem_vld[k] <= 1'b0;
    end else if (sram_en) begin
      if (sram_we != 4'd0) begin
        for (int b = 0; b < 4; b++)
          if (sram_we[b]) mem[mem_idx][8*b +: 8] <= sram_wdata[8*b +: 8];
        mem_vld[mem_idx] <= 1'b1;
      end else begin
        sram_rdata <= mem_vld[mem_idx] ? mem[mem_idx] : ~sram_addr;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_gnt(input int owner, input logic [3:0] we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    gnt_t g;
    g.owner = owner; g.we = we; g.addr = addr; g.wdata = wdata; g.due = cyc;
    gnt_q.push_back(g);
  endtask

  task automatic push_rd(input int owner, input logic [31:0] data);
    rd_t r;
    r.owner = owner; r.data = data; r.due = cyc + 1;
    rd_q.push_back(r);
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented grant / read response with the queues.
  always @(negedge clk) begin
    logic exp_en, exp_rv;
    gnt_t g;
    rd_t  r;
    exp_en = (gnt_q.size() > 0) && (gnt_q[0].due == cyc);
    chk("sram_en", sram_en, exp_en);
    if (exp_en) begin
      g = gnt_q.pop_front();
      if (sram_en) begin
        $display("[TB] cyc %0d grant %s we=%h addr=%08h wdata=%08h",
                 cyc, i_gnt ? "INST" : "DATA", sram_we, sram_addr, sram_wdata);
        chk("i_gnt", i_gnt, g.owner == OWN_I);
        chk("d_gnt", d_gnt, g.owner == OWN_D);
        chk("sram_we", sram_we, g.we);
        chk("sram_addr", sram_addr, g.addr);
        chk("sram_wdata", sram_wdata, g.wdata);
      end
    end else begin
      chk("idle_gnt", {i_gnt, d_gnt}, 0);
      chk("idle_sram_drive", sram_we | sram_addr | sram_wdata, 0);
    end

    exp_rv = (rd_q.size() > 0) && (rd_q[0].due == cyc);
    if (exp_rv) begin
      r = rd_q.pop_front();
      $display("[TB] cyc %0d rvalid i=%0b d=%0b rdata=%08h", cyc, i_rvalid, d_rvalid,
               i_rvalid ? i_rdata : d_rdata);
      chk("i_rvalid", i_rvalid, r.owner == OWN_I);
      chk("d_rvalid", d_rvalid, r.owner == OWN_D);
      chk("rdata", (r.owner == OWN_I) ? i_rdata : d_rdata, r.data);
      chk("other_rdata", (r.owner == OWN_I) ? d_rdata : i_rdata, 0);
    end else begin
      chk("no_rvalid", {i_rvalid, d_rvalid}, 0);
      chk("idle_rdata", i_rdata | d_rdata, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    int pat [8];
`ifdef ARB_STARVE_EN
    pat = '{OWN_D, OWN_D, OWN_D, OWN_I, OWN_D, OWN_D, OWN_D, OWN_I};
`else
    pat = '{OWN_D, OWN_D, OWN_D, OWN_D, OWN_D, OWN_D, OWN_D, OWN_D};
`endif
    resetn = 1'b0; mem_clr = 1'b1;
    i_req = 1'b1; i_we = 4'd0; i_addr = 32'h1C00_0000; i_wdata = 32'd0;
    d_req = 1'b0; d_we = 4'd0; d_addr = 32'd0; d_wdata = 32'd0;

    // Reset held with inst requesting: everything stays at 0.
    repeat (3) begin
      @(negedge clk);
      chk("rst_i_gnt", i_gnt, 0);
      chk("rst_sram_addr", sram_addr, 0);
      chk("rst_conflict_cnt", conflict_cnt, 0);
      chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
    end
    go();
    resetn = 1'b1; mem_clr = 1'b0;
    push_gnt(OWN_I, 4'd0, 32'h1C00_0000, 32'd0);
    push_rd(OWN_I, 32'hE3FF_FFFF);
    go();
    i_req = 1'b0;
    go();

    // Data write then read-back of the same word.
    d_req = 1'b1; d_we = 4'hF; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    push_gnt(OWN_D, 4'hF, 32'h100, 32'hDEAD_BEEF);
    go();
    d_we = 4'd0; d_wdata = 32'd0;
    push_gnt(OWN_D, 4'd0, 32'h100, 32'd0);
    push_rd(OWN_D, 32'hDEAD_BEEF);
    go();
    d_req = 1'b0;
    go();

    // Both ports reading continuously for 8 cycles.
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_addr = 32'h200;
    for (int k = 0; k < 8; k++) begin
      push_gnt(pat[k], 4'd0, (pat[k] == OWN_I) ? 32'h300 : 32'h200, 32'd0);
      push_rd(pat[k], (pat[k] == OWN_I) ? 32'hFFFF_FCFF : 32'hFFFF_FDFF);
      @(negedge clk);
      chk("conflict_cnt_run", conflict_cnt, k);
      go();
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("conflict_cnt_8", conflict_cnt, 8);
    go();

    // Same-address data write vs inst read: inst sees the new value.
    i_req = 1'b1; i_addr = 32'h380;
    d_req = 1'b1; d_we = 4'hF; d_addr = 32'h380; d_wdata = 32'hCAFE_F00D;
    push_gnt(OWN_D, 4'hF, 32'h380, 32'hCAFE_F00D);
    go();
    d_req = 1'b0; d_we = 4'd0; d_wdata = 32'd0;
    push_gnt(OWN_I, 4'd0, 32'h380, 32'd0);
    push_rd(OWN_I, 32'hCAFE_F00D);
    go();
    i_req = 1'b0;
    @(negedge clk);
    chk("conflict_cnt_9", conflict_cnt, 9);
    go();

    // Reset pulsed right after a read grant: the read is discarded.
    d_req = 1'b1; d_addr = 32'h100;
    push_gnt(OWN_D, 4'd0, 32'h100, 32'd0);
    go();
    d_req = 1'b0; resetn = 1'b0;
    @(negedge clk);
    chk("midrst_conflict_cnt", conflict_cnt, 0);
    go(); go();
    resetn = 1'b1;
    repeat (3) go();
    @(negedge clk);
    chk("post_rst_conflict_cnt", conflict_cnt, 0);

    // Saturation from a preloaded counter.
    force dut.r_conflict_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_conflict_cnt;
    go();
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_addr = 32'h200;
    for (int k = 0; k < 3; k++) begin
      push_gnt(OWN_D, 4'd0, 32'h200, 32'd0);
      push_rd(OWN_D, 32'hFFFF_FDFF);
      @(negedge clk);
      chk("sat_conflict_cnt", conflict_cnt, (k == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
      go();
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("sat_conflict_cnt_end", conflict_cnt, 32'hFFFF_FFFF);
    go(); go();
    @(negedge clk);
    chk("sat_conflict_cnt_hold", conflict_cnt, 32'hFFFF_FFFF);

    chk("gnt_q_drained", gnt_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
